vit_bist_checker: RTL and testbench

//  Parametrised built-in self-test for the convolutional encoder / Viterbi decoder pair.
//  - Generates PRBS message blocks and drives the encoder's Ux input.
//  - Passes encoder symbols Vx to the decoder's Rx input, optionally corrupting them.
//  - Checks the decoded Dx stream against a FIFO of the bits it sent.
//  - Counts bit and block errors, then flags pass/fail in hardware.

---
 rtl/vit_bist_pkg.sv | 23 ++
 rtl/vit_ref_fifo.sv | 52 +++++
 rtl/vit_bist_checker.sv | 208 ++++++++++++++++++++
 tb/tb_vit_bist_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vit_bist_pkg.sv
// Shared types and constants for the Viterbi BIST checker: FSM states and the
// x^15+x^14+1 PRBS generator.
package vit_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PRBS_W = 15;

  // Feedback taps at bit positions 14 and 13 (x^15 and x^14 terms).
  localparam logic [PRBS_W-1:0] PRBS_TAPS     = 15'h6000;
  localparam logic [PRBS_W-1:0] SEED_ZERO_SUB = 15'h0001;

  // Fibonacci step: the MSB is the output bit, and feedback enters at the LSB.
  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/vit_ref_fifo.sv
// Single-bit reference FIFO with a power-of-two depth and first-word fall-through.
// It holds the message bits the checker is still waiting to see decoded.
module vit_ref_fifo #(
  parameter int DEPTH = 128
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vit_bist_checker.sv
// BIST checker for the convolutional encoder / Viterbi decoder pair.
// Optional symbol error injection is enabled by defining VIT_BIST_ERR_INJECT_EN.
module vit_bist_checker
  import vit_bist_pkg::*;
#(
  parameter int BLOCK_LEN  = 20,
  parameter int NUM_BLOCKS = 10,
  parameter int N          = 2,
  parameter int MAX_LAT    = 64,
  parameter int CNT_W      = 16,
  parameter int INJ_PERIOD = 37
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [PRBS_W-1:0] seed,
  output logic              Ux,
  output logic              ux_valid,
  input  logic [N-1:0]      Vx,
  output logic [N-1:0]      Rx,
  input  logic              Dx,
  input  logic              Dx_oe,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  blk_err_cnt,
  output logic              timeout
);

  localparam int TOTAL      = BLOCK_LEN * NUM_BLOCKS;
  localparam int SEND_W     = $clog2(TOTAL + 1);
  localparam int IDX_W      = $clog2(BLOCK_LEN + 1);
  localparam int DRAIN_W    = $clog2(2 * MAX_LAT + 1);
  localparam int FIFO_DEPTH = 1 << $clog2(MAX_LAT + 1);

  localparam logic [SEND_W-1:0]  SEND_LAST  = SEND_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(BLOCK_LEN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * MAX_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  state_t             state;
  state_t             next_state;
  logic [PRBS_W-1:0]  lfsr;
  logic [SEND_W-1:0]  send_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic               dirty;
  logic               done_q;
  logic               fail_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   bit_err_q;
  logic [CNT_W-1:0]   blk_err_q;

  logic fifo_push;
  logic fifo_pop;
  logic fifo_clear;
  logic ref_bit;
  logic fifo_full;
  logic fifo_empty;

  logic start_run;
  logic active;
  logic compare_en;
  logic mismatch;
  logic overflow;
  logic blk_wrap;
  logic drain_exit;
  logic drain_expired;

  assign active    = (state == SEND) || (state == DRAIN);
  assign start_run = start && ((state == IDLE) || (state == DONE));

  assign fifo_push  = (state == SEND);
  assign fifo_clear = start_run;
  assign compare_en = active && Dx_oe && !fifo_empty;
  assign fifo_pop   = compare_en;
  assign mismatch   = compare_en && (Dx != ref_bit);
  assign overflow   = fifo_push && fifo_full && !fifo_pop;

  // Expiry is only a timeout if bits are still outstanding; an empty FIFO wins.
  assign drain_expired = (state == DRAIN) && !fifo_empty && (drain_cnt == DRAIN_LAST);
  assign drain_exit    = (state == DRAIN) && (fifo_empty || (drain_cnt == DRAIN_LAST));
  assign blk_wrap      = compare_en && (bit_idx == IDX_LAST);

  vit_ref_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_ref_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (lfsr[PRBS_W-1]),
    .pop       (fifo_pop),
    .pop_data  (ref_bit),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: next_state takes its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SEND;
      SEND:    if (send_cnt == SEND_LAST) next_state = DRAIN;
      DRAIN:   if (drain_exit) next_state = DONE;
      DONE:    if (start) next_state = SEND;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr      <= '0;
      send_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_run)
        lfsr <= (seed == '0) ? SEED_ZERO_SUB : seed;
      else if (state == SEND)
        lfsr <= prbs_next(lfsr);

      if (start_run)          send_cnt <= '0;
      else if (state == SEND) send_cnt <= send_cnt + 1'b1;

      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  // A partial block still open when DRAIN ends is settled in the same way as a wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      dirty     <= 1'b0;
      bit_err_q <= '0;
      blk_err_q <= '0;
    end else if (start_run) begin
      bit_idx   <= '0;
      dirty     <= 1'b0;
      bit_err_q <= '0;
      blk_err_q <= '0;
    end else begin
      if (compare_en) bit_idx <= blk_wrap ? '0 : bit_idx + 1'b1;

      if (blk_wrap || drain_exit) dirty <= 1'b0;
      else if (mismatch)          dirty <= 1'b1;

      if (mismatch && (bit_err_q != CNT_MAX))
        bit_err_q <= bit_err_q + 1'b1;

      if ((blk_wrap || drain_exit) && (dirty || mismatch) && (blk_err_q != CNT_MAX))
        blk_err_q <= blk_err_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (start_run) begin
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (drain_exit)                           done_q    <= 1'b1;
      if (drain_expired)                        timeout_q <= 1'b1;
      if (mismatch || overflow || drain_expired) fail_q   <= 1'b1;
    end
  end

  // Tail bits are zero so the encoder flushes cleanly during DRAIN.
  assign Ux          = (state == SEND) ? lfsr[PRBS_W-1] : 1'b0;
  assign ux_valid    = (state == SEND);
  assign busy        = active;
  assign done        = done_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign bit_err_cnt = bit_err_q;
  assign blk_err_cnt = blk_err_q;

`ifdef VIT_BIST_ERR_INJECT_EN
  localparam int              INJ_W    = $clog2(INJ_PERIOD + 1);
  localparam logic [INJ_W-1:0] INJ_LAST = INJ_W'(INJ_PERIOD - 1);

  logic [INJ_W-1:0] inj_cnt;
  logic             inject;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          inj_cnt <= '0;
    else if (start_run) inj_cnt <= '0;
    else if (active)    inj_cnt <= (inj_cnt == INJ_LAST) ? '0 : inj_cnt + 1'b1;
  end

  // Flip only the LSB so the decoder sees an isolated, correctable symbol error.
  assign inject = active && (inj_cnt == INJ_LAST);
  assign Rx     = Vx ^ N'(inject);
`else
  assign Rx = Vx;
`endif

endmodule

// File: tb/tb_vit_bist_checker.sv
// Directed testbench for vit_bist_checker using a loopback "decoder" (delay line
// of Ux/ux_valid) and scoreboard queues for the message bits and the run results.
module tb_vit_bist_checker;

  localparam int TOTAL = 200;
  localparam int DLY   = 7;

  typedef struct {
    logic [15:0] bit_err;
    logic [15:0] blk_err;
    logic        fail;
    logic        timeout;
  } result_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] seed;
  logic        Ux;
  logic        ux_valid;
  logic [1:0]  Vx;
  logic [1:0]  Rx;
  logic        Dx;
  logic        Dx_oe;
  logic        busy;
  logic        done;
  logic        fail;
  logic [15:0] bit_err_cnt;
  logic [15:0] blk_err_cnt;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic    exp_ux_q[$];
  result_t res_q[$];

  bit loop_oe_en;
  bit err_all;
  int err_idx;
  int sent_idx;

  logic dly_d[DLY+1];
  logic dly_v[DLY+1];

  vit_bist_checker dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
    .Ux          (Ux),
    .ux_valid    (ux_valid),
    .Vx          (Vx),
    .Rx          (Rx),
    .Dx          (Dx),
    .Dx_oe       (Dx_oe),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .bit_err_cnt (bit_err_cnt),
    .blk_err_cnt (blk_err_cnt),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loopback decoder and Ux scoreboard: everything runs on the falling edge,
  // so DUT outputs are stable and Dx/Dx_oe change away from the active edge.
  initial begin
    logic inv;
    logic e;
    Dx    = 1'b0;
    Dx_oe = 1'b0;
    for (int i = 0; i <= DLY; i++) begin
      dly_d[i] = 1'b0;
      dly_v[i] = 1'b0;
    end
    forever begin
      @(negedge clock);
      inv = 1'b0;
      if (reset === 1'b1) begin
        for (int i = 0; i <= DLY; i++) begin
          dly_d[i] = 1'b0;
          dly_v[i] = 1'b0;
        end
      end else begin
        if (ux_valid === 1'b1) begin
          if (exp_ux_q.size() == 0) begin
            check("ux_extra", exp_ux_q.size(), 1);
          end else begin
            e = exp_ux_q.pop_front();
            check("ux_bit", Ux, e);
          end
          inv = err_all || (sent_idx == err_idx);
          sent_idx++;
        end
        for (int i = DLY; i > 0; i--) begin
          dly_d[i] = dly_d[i-1];
          dly_v[i] = dly_v[i-1];
        end
        dly_v[0] = (ux_valid === 1'b1) && loop_oe_en;
        dly_d[0] = Ux ^ inv;
      end
      Dx    = dly_d[DLY];
      Dx_oe = dly_v[DLY];
    end
  end

  task automatic load_expected(input logic [14:0] s);
    logic [14:0] l;
    l = (s == 15'd0) ? 15'h0001 : s;
    for (int i = 0; i < TOTAL; i++) begin
      exp_ux_q.push_back(l[14]);
      l = {l[13:0], l[14] ^ l[13]};
    end
  endtask

  task automatic pulse_start(input logic [14:0] s, input bit oe_en, input int e_idx, input bit e_all);
    loop_oe_en = oe_en;
    err_idx    = e_idx;
    err_all    = e_all;
    sent_idx   = 0;
    seed       = s;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run(input string name, input logic [14:0] s, input bit oe_en, input int e_idx,
                     input bit e_all, input result_t exp, input int lat_min, input int lat_max);
    result_t r;
    int lat;
    load_expected(s);
    res_q.push_back(exp);
    pulse_start(s, oe_en, e_idx, e_all);
    check({name, "_started_busy"}, busy, 1'b1);
    check({name, "_started_done"}, done, 1'b0);
    lat = 1;
    while (done !== 1'b1 && lat < 1000) begin
      @(negedge clock);
      lat++;
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_latency_ok"}, (lat >= lat_min) && (lat <= lat_max), 1'b1);
    r = res_q.pop_front();
    check({name, "_bit_err"}, bit_err_cnt, r.bit_err);
    check({name, "_blk_err"}, blk_err_cnt, r.blk_err);
    check({name, "_fail"}, fail, r.fail);
    check({name, "_timeout"}, timeout, r.timeout);
    check({name, "_idle_busy"}, busy, 1'b0);
    check({name, "_ux_drained"}, exp_ux_q.size(), 0);
    repeat (3) @(negedge clock);
    check({name, "_done_holds"}, done, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_Ux"}, Ux, 1'b0);
    check({name, "_ux_valid"}, ux_valid, 1'b0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_fail"}, fail, 1'b0);
    check({name, "_bit_err"}, bit_err_cnt, 16'd0);
    check({name, "_blk_err"}, blk_err_cnt, 16'd0);
    check({name, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    seed       = '0;
    Vx         = '0;
    loop_oe_en = 1'b1;
    err_all    = 1'b0;
    err_idx    = -1;
    sent_idx   = 0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    Vx = 2'b01;
    #1 check("rx_pass_01", Rx, 2'b01);
    Vx = 2'b10;
    #1 check("rx_pass_10", Rx, 2'b10);
    Vx = 2'b11;
    #1 check("rx_pass_11", Rx, 2'b11);
    Vx = 2'b00;

    // Clean loopback: last compare 8 edges after the last Ux, DONE one edge later.
    run("loop_clean", 15'h1ACE, 1'b1, -1, 1'b0, '{16'd0, 16'd0, 1'b0, 1'b0}, 207, 211);

    // Single inverted bit at index 45 lands in block 2.
    run("loop_bit45", 15'h1ACE, 1'b1, 45, 1'b0, '{16'd1, 16'd1, 1'b1, 1'b0}, 207, 211);

    // Every decoded bit wrong: all 200 bits and all 10 blocks count.
    run("loop_all_inv", 15'h2B3C, 1'b1, -1, 1'b1, '{16'd200, 16'd10, 1'b1, 1'b0}, 207, 211);

    // No Dx_oe at all: FIFO overflows during SEND, then DRAIN runs its full 128 cycles.
    run("no_oe_timeout", 15'h1ACE, 1'b0, -1, 1'b0, '{16'd0, 16'd0, 1'b1, 1'b1}, 327, 331);

    // Seed 0 runs as seed 1; a restart from DONE also flushes the stale FIFO.
    run("seed_zero", 15'h0000, 1'b1, -1, 1'b0, '{16'd0, 16'd0, 1'b0, 1'b0}, 207, 211);

    // Reset in the middle of SEND, with a bit error already counted.
    load_expected(15'h1ACE);
    pulse_start(15'h1ACE, 1'b1, 10, 1'b0);
    repeat (49) @(negedge clock);
    check("mid_run_busy", busy, 1'b1);
    check("mid_run_bit_err", bit_err_cnt, 16'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    exp_ux_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run("after_reset", 15'h1ACE, 1'b1, -1, 1'b0, '{16'd0, 16'd0, 1'b0, 1'b0}, 207, 211);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
